fp_round_pipe: RTL and testbench
================================

Name: fp_round_pipe

Overview:
- Pipelined final rounding/packing stage directly downstream of fp_fma (and of fp_add/fp_mul).
- Consumes a Structs#(FP_FORMAT)::uround_res_t (unrounded sign/exp/mant, round+sticky, round_en, invalid, exp_cout) plus rounding mode.
- Produces the IEEE-754 packed result and exception flags through a 2-stage valid/ready pipeline with full backpressure.
- Lets the combinational arithmetic stages stay unregistered while the FPU top sees a timed, stallable output.

Parameters:
FP_FORMAT, FP32, fp_format_e format; FP_WIDTH/EXP_WIDTH/MANT_WIDTH derived via fp_width/exp_bits/man_bits (localparams).

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  upstream result valid
ready_o  output  1  stage 1 can accept
urnd_result_i  input  uround_res_t  unrounded result from arithmetic stage
rnd_i  input  roundmode_e  rounding mode, sampled with the beat
valid_o  output  1  result_o/flags_o valid
ready_i  input  1  downstream accepts
result_o  output  FP_WIDTH  rounded packed result
flags_o  output  5  {NV,DZ,OF,UF,NX}; DZ always 0

Behaviour:
- Reset (async, rst_ni=0): both stage valid bits 0, valid_o=0, result_o=0, flags_o=0; ready_o=1 once reset releases. Reset mid-operation discards in-flight beats.
- Handshake: a beat transfers on valid_i&ready_o, and on valid_o&ready_i. Latency is exactly 2 cycles when unstalled; throughput is 1 beat/cycle. Order is preserved and nothing is dropped or duplicated.
- Stage advance: stage 2 loads when it is empty or ready_i=1. Stage 1 loads when it is empty or advancing. ready_o = ~s1_valid | s1_advance, so ready_o is combinational from ready_i.
- Holding: while stalled, stage registers and the outputs hold their values, including with valid_o=1.
- Stage 1 work: register the input and compute the increment from rs={r,s}, the mantissa LSB, sign and rnd_i:
  - RNE: r&(s|lsb)
  - RTZ: 0
  - RDN: sign&(r|s)
  - RUP: ~sign&(r|s)
  - RMM: r
  - inexact = r|s
- Stage 2 work: form {exp,mant}+inc as an (EXP_WIDTH+MANT_WIDTH+1)-bit add, so the mantissa carry propagates into the exponent.
- Priority, highest first:
  1. invalid=1: result = canonical qNaN (sign 0, exp all 1s, mant MSB 1, rest 0). Flags NV only.
  2. round_en=0: u_result passes through unchanged. Flags 0.
  3. exp_cout=2'b01 (pre-round overflow), or the rounded exponent reaches all 1s: OF|NX. Result is inf or max-finite by mode:
     - RNE/RMM: inf.
     - RTZ: max-finite.
     - RDN: inf if sign=1, else max-finite.
     - RUP: inf if sign=0, else max-finite.
     - RTZ with no pre-round overflow cannot increment, so it never sets OF.
  4. exp_cout[1]=1 (exponent underflow): result = signed zero, UF|NX. RUP/RDN in the away direction give the min subnormal (mant=1).
  5. Otherwise: rounded value, NX=inexact; UF = inexact & (rounded exp==0).
- Inputs with u_result already inf (exp all 1s, mant 0, rs=0) pass with flags 0.
- rnd_i encodings outside the five modes behave as RNE.

Test Plan:
- FP32, u_result=0x3F800000, rs=2'b11, RNE, round_en=1 -> 2 cycles later result_o=0x3F800001, flags_o=5'b00001.
- Ties: u_result=0x3F800000 rs=2'b10 RNE -> 0x3F800000 NX. u_result=0x3F800001 rs=2'b10 RNE -> 0x3F800002 NX. Same 0x3F800000 with RMM -> 0x3F800001.
- Overflow: u_result=0x7F7FFFFF rs=2'b10:
  - RNE -> 0x7F800000, flags 5'b00101.
  - RTZ -> 0x7F7FFFFF, flags 5'b00001.
  - Sign 1, exp_cout=2'b01, RUP -> 0xFF7FFFFF, flags 5'b00101.
- Special inputs:
  - invalid=1 -> 0x7FC00000, flags 5'b10000.
  - round_en=0, u_result=0x12345678, rs=2'b11 -> 0x12345678, flags 0.
  - exp_cout=2'b10, sign 0, RNE -> 0x00000000, flags 5'b00011.
- Backpressure: stream 4 beats back-to-back with ready_i=0 for cycles 2-5.
  - ready_o drops after 2 beats are held; valid_o stays 1 with the first result stable.
  - On release, all 4 results emerge in order, one per cycle, with none lost.
- Reset: assert rst_ni=0 asynchronously mid-stream with valid_o=1 -> valid_o, result_o, flags_o go 0 immediately without a clock edge. The first post-reset beat appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage valid/ready rounding and packing stage for FP results.
// Stage 1 captures the beat and decides the increment; stage 2 applies it and selects the packed result.
package fp_round_pkg;
  typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  function automatic int fp_width(fp_format_e f);
    case (f)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int exp_bits(fp_format_e f);
    case (f)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int man_bits(fp_format_e f);
    case (f)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    fp32_t       u_result;
    logic [1:0]  rs;
    logic        round_en;
    logic        invalid;
    logic [1:0]  exp_cout;
  } uround_res_fp32_t;
endpackage

module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter fp_format_e FP_FORMAT    = FP32,
  parameter type        uround_res_t = uround_res_fp32_t
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  uround_res_t                       urnd_result_i,
  input  roundmode_e                        rnd_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [fp_width(FP_FORMAT)-1:0]    result_o,
  output logic [4:0]                        flags_o
);
  localparam int FP_WIDTH   = fp_width(FP_FORMAT);
  localparam int EXP_WIDTH  = exp_bits(FP_FORMAT);
  localparam int MANT_WIDTH = man_bits(FP_FORMAT);
  localparam int SUM_W      = EXP_WIDTH + MANT_WIDTH + 1;
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_MAXF = EXP_ONES - 1'b1;

  logic                  s1_valid, s2_valid, s1_advance, s2_advance;
  logic [FP_WIDTH-1:0]   s1_res;
  logic                  s1_round_en, s1_invalid, s1_inc, s1_inexact;
  logic [1:0]            s1_exp_cout;
  roundmode_e            s1_rnd;

  logic                  inc_d, r_bit, s_bit, lsb, in_sign;
  logic [SUM_W-1:0]      sum;
  logic [EXP_WIDTH-1:0]  rnd_exp, exp_in;
  logic                  sign, use_inf, away, of_hit;
  logic [FP_WIDTH-1:0]   res_d;
  logic [4:0]            flags_d;

  // ready_o looks through to ready_i so a full pipe still streams one beat per cycle
  assign s2_advance = ~s2_valid | ready_i;
  assign s1_advance = s1_valid & s2_advance;
  assign ready_o    = ~s1_valid | s1_advance;
  assign valid_o    = s2_valid;

  always_comb begin
    r_bit   = urnd_result_i.rs[1];
    s_bit   = urnd_result_i.rs[0];
    lsb     = urnd_result_i.u_result.mant[0];
    in_sign = urnd_result_i.u_result.sign;
    inc_d   = r_bit & (s_bit | lsb);
    case (rnd_i)
      RTZ:     inc_d = 1'b0;
      RDN:     inc_d = in_sign & (r_bit | s_bit);
      RUP:     inc_d = ~in_sign & (r_bit | s_bit);
      RMM:     inc_d = r_bit;
      default: inc_d = r_bit & (s_bit | lsb);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_res      <= '0;
      s1_round_en <= 1'b0;
      s1_invalid  <= 1'b0;
      s1_exp_cout <= 2'b00;
      s1_rnd      <= RNE;
      s1_inc      <= 1'b0;
      s1_inexact  <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_res      <= urnd_result_i.u_result;
        s1_round_en <= urnd_result_i.round_en;
        s1_invalid  <= urnd_result_i.invalid;
        s1_exp_cout <= urnd_result_i.exp_cout;
        s1_rnd      <= rnd_i;
        s1_inc      <= inc_d;
        s1_inexact  <= |urnd_result_i.rs;
      end
    end
  end

  // An input already at exponent all-ones (inf) is left alone rather than flagged as overflow
  always_comb begin
    sign    = s1_res[FP_WIDTH-1];
    exp_in  = s1_res[FP_WIDTH-2 -: EXP_WIDTH];
    sum     = {1'b0, s1_res[FP_WIDTH-2:0]} + SUM_W'(s1_inc);
    rnd_exp = sum[SUM_W-2 -: EXP_WIDTH];
    case (s1_rnd)
      RTZ:     use_inf = 1'b0;
      RDN:     use_inf = sign;
      RUP:     use_inf = ~sign;
      default: use_inf = 1'b1;
    endcase
    case (s1_rnd)
      RDN:     away = sign;
      RUP:     away = ~sign;
      default: away = 1'b0;
    endcase
    of_hit  = (s1_exp_cout == 2'b01) | ((rnd_exp == EXP_ONES) & (exp_in != EXP_ONES));
    res_d   = {sign, sum[SUM_W-2:0]};
    flags_d = {3'b000, s1_inexact & (rnd_exp == '0), s1_inexact};
    if (s1_invalid) begin
      res_d   = {1'b0, EXP_ONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};
      flags_d = 5'b10000;
    end else if (!s1_round_en) begin
      res_d   = s1_res;
      flags_d = 5'b00000;
    end else if (of_hit) begin
      res_d   = use_inf ? {sign, EXP_ONES, {MANT_WIDTH{1'b0}}}
                        : {sign, EXP_MAXF, {MANT_WIDTH{1'b1}}};
      flags_d = 5'b00101;
    end else if (s1_exp_cout[1]) begin
      res_d   = {sign, {(FP_WIDTH-2){1'b0}}, away};
      flags_d = 5'b00011;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o <= res_d;
        flags_o  <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed self-checking bench for fp_round_pipe in FP32.
// Expected results are hand-computed IEEE-754 single-precision values.
module tb_fp_round_pipe;
  import fp_round_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_i, ready_o, valid_o, ready_i;
  uround_res_fp32_t urnd;
  roundmode_e       rnd;
  logic [31:0]      result_o;
  logic [4:0]       flags_o;
  int               checks = 0;
  int               errors = 0;

  fp_round_pipe #(.FP_FORMAT(FP32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .urnd_result_i (urnd),
    .rnd_i         (rnd),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .flags_o       (flags_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] u, input logic [1:0] rs, input logic ren,
                                input logic inv, input logic [1:0] ec, input roundmode_e m);
    urnd.u_result = u;
    urnd.rs       = rs;
    urnd.round_en = ren;
    urnd.invalid  = inv;
    urnd.exp_cout = ec;
    rnd           = m;
    valid_i       = 1'b1;
  endtask

  task automatic run_beat(input string tag, input logic [31:0] u, input logic [1:0] rs,
                          input logic ren, input logic inv, input logic [1:0] ec,
                          input roundmode_e m, input logic [31:0] er, input logic [4:0] ef);
    @(negedge clk);
    apply_stimulus(u, rs, ren, inv, ec, m);
    @(negedge clk);
    valid_i = 1'b0;
    check_output({tag, "_lat1"}, 32'(valid_o), 32'd0);
    @(negedge clk);
    check_output({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_output({tag, "_res"}, result_o, er);
    check_output({tag, "_flags"}, 32'(flags_o), 32'(ef));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    urnd    = '0;
    rnd     = RNE;
    #1;
    check_output("rst_valid", 32'(valid_o), 32'd0);
    check_output("rst_res", result_o, 32'h0);
    check_output("rst_flags", 32'(flags_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_ready", 32'(ready_o), 32'd1);

    run_beat("rne_up",    32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800001, 5'b00001);
    run_beat("tie_even",  32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001);
    run_beat("tie_odd",   32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001);
    run_beat("tie_rmm",   32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001);
    run_beat("of_rne",    32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00101);
    run_beat("of_rtz",    32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, RTZ, 32'h7F7FFFFF, 5'b00001);
    run_beat("of_rup_n",  32'hFF7FFFFF, 2'b10, 1'b1, 1'b0, 2'b01, RUP, 32'hFF7FFFFF, 5'b00101);
    run_beat("invalid",   32'h3F800000, 2'b11, 1'b1, 1'b1, 2'b00, RNE, 32'h7FC00000, 5'b10000);
    run_beat("no_round",  32'h12345678, 2'b11, 1'b0, 1'b0, 2'b00, RNE, 32'h12345678, 5'b00000);
    run_beat("uf_rne",    32'h00000000, 2'b11, 1'b1, 1'b0, 2'b10, RNE, 32'h00000000, 5'b00011);
    run_beat("uf_rup",    32'h00000000, 2'b11, 1'b1, 1'b0, 2'b10, RUP, 32'h00000001, 5'b00011);
    run_beat("carry",     32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h40000000, 5'b00001);
    run_beat("rtz_trunc", 32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, RTZ, 32'h3F800000, 5'b00001);
    run_beat("rdn_neg",   32'hBF800000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'h BF800001, 5'b00001);
    run_beat("inf_pass",  32'h7F800000, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00000);
    run_beat("tiny_nx",   32'h00000005, 2'b01, 1'b1, 1'b0, 2'b00, RNE, 32'h00000005, 5'b00011);
    run_beat("bad_mode",  32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, roundmode_e'(3'b111),
             32'h3F800000, 5'b00001);

    // Backpressure: four beats, downstream stalls after the first arrives
    @(negedge clk);
    ready_i = 1'b1;
    apply_stimulus(32'h40000000, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
    @(negedge clk);
    apply_stimulus(32'h40000010, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
    ready_i = 1'b0;
    @(negedge clk);
    apply_stimulus(32'h40000020, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
    check_output("bp_ready_drop", 32'(ready_o), 32'd0);
    check_output("bp_valid", 32'(valid_o), 32'd1);
    check_output("bp_first", result_o, 32'h40000001);
    repeat (3) begin
      @(negedge clk);
      check_output("bp_hold_ready", 32'(ready_o), 32'd0);
      check_output("bp_hold_valid", 32'(valid_o), 32'd1);
      check_output("bp_hold_res", result_o, 32'h40000001);
      check_output("bp_hold_flags", 32'(flags_o), 32'h1);
    end
    ready_i = 1'b1;
    #1;
    check_output("bp_ready_comb", 32'(ready_o), 32'd1);
    @(negedge clk);
    check_output("bp_out1", result_o, 32'h40000011);
    apply_stimulus(32'h40000030, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
    @(negedge clk);
    valid_i = 1'b0;
    check_output("bp_out2", result_o, 32'h40000021);
    @(negedge clk);
    check_output("bp_out3", result_o, 32'h40000031);
    check_output("bp_out3_valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    check_output("bp_drained", 32'(valid_o), 32'd0);

    // Asynchronous reset while a result is held at the output
    @(negedge clk);
    apply_stimulus(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
    ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    check_output("ar_pre_valid", 32'(valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("ar_valid", 32'(valid_o), 32'd0);
    check_output("ar_res", result_o, 32'h0);
    check_output("ar_flags", 32'(flags_o), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    #1;
    check_output("ar_ready", 32'(ready_o), 32'd1);
    apply_stimulus(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE);
    @(negedge clk);
    valid_i = 1'b0;
    check_output("ar_lat1", 32'(valid_o), 32'd0);
    @(negedge clk);
    check_output("ar_lat2", 32'(valid_o), 32'd1);
    check_output("ar_res2", result_o, 32'h3F800002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
